// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B4 incrementing-burst master with retry/abort status.
// Optional abort on a silent slave: define WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 16,
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst,
  output logic [AW-1:0]              wb_adr_o,
  output logic [DW-1:0]              wb_dat_o,
  output logic [DW/8-1:0]            wb_sel_o,
  output logic                       wb_we_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic [2:0]                 wb_cti_o,
  output logic [1:0]                 wb_bte_o,
  input  logic [DW-1:0]              wb_dat_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i,
  input  logic                       wb_rty_i,
  input  logic                       start,
  input  logic [AW-1:0]              address,
  input  logic [DW/8-1:0]            selection,
  input  logic                       write,
  input  logic [$clog2(MAX_BURST):0] length,
  input  logic [DW-1:0]              wr_data,
  output logic                       wr_pop,
  output logic [DW-1:0]              rd_data,
  output logic                       rd_valid,
  output logic                       active,
  output logic                       done,
  output logic [1:0]                 error_code
);

  localparam int SW = DW / 8;
  localparam int LW = $clog2(MAX_BURST) + 1;
  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_BACKOFF,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] adr_q;
  logic [SW-1:0] sel_q;
  logic          we_q;
  logic          single_q;
  logic [LW-1:0] beats_q;
  logic [LW-1:0] len_eff;
  logic [RW-1:0] retry_q;
  logic [1:0]    code_q;
  logic          bus;
  logic          take;
  logic          ack_ok;
  logic          rty_hit;
  logic          err_hit;
  logic          tmo_hit;
  logic          last;
  logic          retry_over;

  assign bus        = (state == S_BUS);
  assign take       = (state == S_IDLE) & start;
  assign err_hit    = bus & wb_err_i;
  assign rty_hit    = bus & ~wb_err_i & wb_rty_i;
  assign ack_ok     = bus & ~wb_err_i & ~wb_rty_i & wb_ack_i;
  assign last       = (beats_q == LW'(1));
  assign retry_over = (retry_q >= RMAX);

  assign wb_adr_o   = adr_q;
  assign wb_bte_o   = 2'b00;
  assign error_code = code_q;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);
  logic [31:0] tmo_q;
  logic        silent;

  assign silent  = bus & ~wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign tmo_hit = silent & (tmo_q == TLIM);

  // count silent bus cycles; any response or leaving BUS restarts it
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      tmo_q <= '0;
    end else if (silent) begin
      tmo_q <= tmo_q + 32'd1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
  assign tmo_hit    = 1'b0;
`endif

  // zero-length means one beat, oversize requests clamp to a full burst
  always_comb begin
    len_eff = length;
    if (length == '0) begin
      len_eff = LW'(1);
    end else if (length > LW'(MAX_BURST)) begin
      len_eff = LW'(MAX_BURST);
    end
  end

  // state register
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state and bus/user strobes; err beats rty beats ack
  always_comb begin
    state_nx = state;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = '0;
    wb_dat_o = '0;
    wb_cti_o = 3'b000;
    wr_pop   = 1'b0;
    active   = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_BUS;
      end
      S_BUS: begin
        active   = 1'b1;
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = we_q;
        wb_sel_o = sel_q;
        wb_dat_o = we_q ? wr_data : '0;
        wb_cti_o = single_q ? 3'b000 :
                   (last ? 3'b111 : 3'b010);
        wr_pop   = ack_ok & we_q;
        if (err_hit || tmo_hit) begin
          state_nx = S_DONE;
        end else if (rty_hit) begin
          state_nx = retry_over ? S_DONE : S_BACKOFF;
        end else if (ack_ok && last) begin
          state_nx = S_DONE;
        end
      end
      S_BACKOFF: begin
        active   = 1'b1;
        state_nx = S_BUS;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // command latch, beat bookkeeping, read capture and status
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      adr_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      single_q <= 1'b0;
      beats_q  <= '0;
      retry_q  <= '0;
      code_q   <= 2'b00;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      unique case (1'b1)
        take: begin
          adr_q    <= address;
          sel_q    <= selection;
          we_q     <= write;
          beats_q  <= len_eff;
          single_q <= (len_eff == LW'(1));
          retry_q  <= '0;
          code_q   <= 2'b00;
        end
        ack_ok: begin
          adr_q   <= adr_q + AW'(SW);
          beats_q <= beats_q - LW'(1);
          if (!we_q) begin
            rd_data  <= wb_dat_i;
            rd_valid <= 1'b1;
          end
        end
        err_hit: begin
          code_q <= 2'b01;
        end
        rty_hit: begin
          if (retry_over) begin
            code_q <= 2'b10;
          end else begin
            retry_q <= retry_q + RW'(1);
          end
        end
        tmo_hit: begin
          code_q <= 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule
